dct_block_collector: RTL and testbench
======================================

Name: dct_block_collector

Overview:
- Receive end of the DCT output protocol: captures each 64-coefficient block the dct presents on dout while done is high.
- Requantizes each coefficient to the top QBits bits, sign-extended to full width, which is the format the idct consumes on din.
- Replays each block as a valid/ready stream. Two-bank ping-pong buffering lets one block drain while the next is captured.
- Sits between dct and idct, or between dct and an output writer.

Parameters:
- BitWidth, 31: MSB index of data words; words are BitWidth+1 bits wide.
- QBits, 14: coefficient bits kept, taken from dout[BitWidth:BitWidth-QBits+1].
- BlockLen, 64: coefficients per block.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- done  in  1  from dct; high while a block is presented, one word per cycle.
- din  in  BitWidth+1  dct coefficient word (dct dout).
- out_valid  out  1  output word available.
- out_ready  in  1  consumer accepts word when out_valid && out_ready.
- out_data  out  BitWidth+1  requantized, sign-extended coefficient.
- out_last  out  1  high with the 64th word of a block.
- overflow  out  1  one-cycle pulse when an incoming block is dropped.
- short_blk  out  1  one-cycle pulse when done falls before BlockLen words.
- blk_count  out  16  blocks fully captured since reset; wraps at 65535→0.

Behaviour:
- Reset (async assert, sync release):
  - out_valid, out_last, overflow, short_blk = 0; out_data = 0; blk_count = 0.
  - Both banks empty; write and read bank pointers = 0; capture FSM in IDLE.
- Requantization: stored word = {(BitWidth+1-QBits) copies of din[BitWidth], din[BitWidth:BitWidth-QBits+1]}. Applied at capture. Example: din = 32'hFFFC_0000 → 32'hFFFF_FFFF.
- Capture FSM states:
  - IDLE:
    - On done=1 with the write bank empty: store din at index 0 this cycle, cnt = 1, go to CAPT.
    - On done=1 with the write bank full: go to DROP and pulse overflow in the same cycle.
  - CAPT:
    - Each cycle with done=1: store din at index cnt, cnt++.
    - When the word at index BlockLen-1 is stored: mark bank full, toggle the write pointer, increment blk_count, go to HOLD.
    - If done=0 before that: discard the partial block (bank stays empty), pulse short_blk, go to IDLE.
  - HOLD: done still high after 64 words; extra words are ignored. Go to IDLE when done=0.
  - DROP: ignore words until done=0, then go to IDLE. blk_count is unchanged.
- A new block is recognised only on a done 0→1 transition seen from IDLE. done must be low at least one cycle between blocks.
- Read side:
  - out_valid = 1 whenever the read bank is full.
  - out_data = read_bank[rd_idx], registered; zero added latency once the bank is marked full.
  - Earliest out_valid is the cycle after the 64th word is captured.
  - On each handshake rd_idx++.
  - out_last = out_valid && rd_idx == BlockLen-1.
  - Handshake on the last word: rd_idx = 0, mark bank empty, toggle the read pointer.
  - If the other bank is already full, out_valid stays 1 the next cycle with that bank's index 0 (back-to-back blocks, no bubble).
  - out_ready may be held low indefinitely; out_data and out_last stay stable while out_valid && !out_ready.
- Simultaneous events:
  - Read bank freed in the same cycle a new done arrives in IDLE with that bank as write target: the bank counts as empty. The free takes effect first and the block is captured.
  - Capture and drain of different banks proceed independently every cycle.
- Reset asserted mid-block or mid-drain: all state is cleared immediately and the partial block is lost. After release, a done already high is ignored until it goes low and high again (FSM requires the 0→1 edge).
- Storage: 2×BlockLen words of BitWidth+1 bits, registers or inferred RAM, with read data registered.

Test Plan:
- Single block: done high 64 cycles, din = k<<18 for k = 0..63, out_ready = 1 → 64 out words with out_data = k, out_last only on k = 63, blk_count = 1.
- Sign extension: din = 32'hFFFC_0000 and 32'h8000_0000 → out_data = 32'hFFFF_FFFF and 32'hFFFF_E000.
- Backpressure ping-pong: three back-to-back blocks with out_ready = 0 → blocks 1 and 2 captured. Block 3 → overflow pulse, blk_count = 2. Then out_ready = 1 → 128 words, no gap between blocks.
- Short block: done high 40 cycles → short_blk pulse, no out_valid, blk_count unchanged. A following 64-word block is delivered normally.
- Long done: done high 70 cycles → exactly 64 words output, words 65–70 ignored.
- Reset mid-capture: assert reset at word 30 with done still high → all outputs 0. After release, nothing is captured until done toggles low then high.

Source files
------------

// File: rtl/dct_block_collector.sv
// Collects 64-coefficient blocks from the dct output, requantizes them to the idct
// input format, and replays them as a valid/ready stream through two ping-pong banks.
module dct_block_collector #(
  parameter int BitWidth = 31,
  parameter int QBits    = 14,
  parameter int BlockLen = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              done,
  input  logic [BitWidth:0] din,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BitWidth:0] out_data,
  output logic              out_last,
  output logic              overflow,
  output logic              short_blk,
  output logic [15:0]       blk_count
);

  localparam int IdxW = (BlockLen > 1) ? $clog2(BlockLen) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(BlockLen - 1);

  typedef enum logic [1:0] {IDLE, CAPT, HOLD, DROP} state_t;

  state_t            state_r;
  logic [BitWidth:0] mem_r [2][BlockLen];
  logic [1:0]        full_r;
  logic              wr_ptr_r, rd_ptr_r, done_prev_r;
  logic [IdxW-1:0]   cnt_r, rd_idx_r;
  logic              out_valid_r, out_last_r, overflow_r, short_r;
  logic [BitWidth:0] out_data_r;
  logic [15:0]       blk_count_r;

  logic              hs_s, free_s, rd_ptr_nxt_s, start_s, we_s, set_s, valid_nxt_s;
  logic [IdxW-1:0]   rd_idx_nxt_s, widx_s;
  logic [1:0]        full_freed_s, full_nxt_s;

  function automatic logic [BitWidth:0] requant(input logic [BitWidth:0] w);
    return {{(BitWidth + 1 - QBits){w[BitWidth]}}, w[BitWidth -: QBits]};
  endfunction

  // Read side: handshake, bank release and next read position.
  always_comb begin
    hs_s   = out_valid_r && out_ready;
    free_s = hs_s && (rd_idx_r == LastIdx);
    if (free_s) begin
      rd_idx_nxt_s = {IdxW{1'b0}};
    end else if (hs_s) begin
      rd_idx_nxt_s = rd_idx_r + IdxW'(1);
    end else begin
      rd_idx_nxt_s = rd_idx_r;
    end
    rd_ptr_nxt_s = rd_ptr_r ^ free_s;
    full_freed_s = full_r;
    if (free_s) begin
      full_freed_s[rd_ptr_r] = 1'b0;
    end else begin
      full_freed_s = full_r;
    end
  end

  // Write side: a bank freed this cycle is already available to a starting block.
  always_comb begin
    start_s = (state_r == IDLE) && done && !done_prev_r;
    we_s    = 1'b0;
    widx_s  = cnt_r;
    set_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (start_s && !full_freed_s[wr_ptr_r]) begin
          we_s   = 1'b1;
          widx_s = {IdxW{1'b0}};
        end else begin
          we_s = 1'b0;
        end
      end
      CAPT: begin
        if (done) begin
          we_s  = 1'b1;
          set_s = (cnt_r == LastIdx);
        end else begin
          we_s = 1'b0;
        end
      end
      default: we_s = 1'b0;
    endcase
    full_nxt_s = full_freed_s;
    if (set_s) begin
      full_nxt_s[wr_ptr_r] = 1'b1;
    end else begin
      full_nxt_s = full_freed_s;
    end
    valid_nxt_s = full_nxt_s[rd_ptr_nxt_s];
  end

  // Coefficient storage, requantized on the way in.
  always_ff @(posedge clk) begin
    if (we_s) begin
      mem_r[wr_ptr_r][widx_s] <= requant(din);
    end
  end

  // Capture FSM, bank bookkeeping and registered stream outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      full_r      <= 2'b00;
      wr_ptr_r    <= 1'b0;
      rd_ptr_r    <= 1'b0;
      cnt_r       <= {IdxW{1'b0}};
      rd_idx_r    <= {IdxW{1'b0}};
      done_prev_r <= 1'b1;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      out_data_r  <= {(BitWidth + 1){1'b0}};
      overflow_r  <= 1'b0;
      short_r     <= 1'b0;
      blk_count_r <= 16'd0;
    end else begin
      done_prev_r <= done;
      full_r      <= full_nxt_s;
      rd_ptr_r    <= rd_ptr_nxt_s;
      rd_idx_r    <= rd_idx_nxt_s;
      out_valid_r <= valid_nxt_s;
      out_last_r  <= valid_nxt_s && (rd_idx_nxt_s == LastIdx);
      out_data_r  <= valid_nxt_s ? mem_r[rd_ptr_nxt_s][rd_idx_nxt_s] : {(BitWidth + 1){1'b0}};
      overflow_r  <= 1'b0;
      short_r     <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start_s && full_freed_s[wr_ptr_r]) begin
            state_r    <= DROP;
            overflow_r <= 1'b1;
          end else if (start_s) begin
            state_r <= CAPT;
            cnt_r   <= IdxW'(1);
          end else begin
            state_r <= IDLE;
          end
        end
        CAPT: begin
          if (done && set_s) begin
            state_r     <= HOLD;
            wr_ptr_r    <= ~wr_ptr_r;
            blk_count_r <= blk_count_r + 16'd1;
            cnt_r       <= {IdxW{1'b0}};
          end else if (done) begin
            cnt_r <= cnt_r + IdxW'(1);
          end else begin
            state_r <= IDLE;
            short_r <= 1'b1;
            cnt_r   <= {IdxW{1'b0}};
          end
        end
        HOLD, DROP: begin
          if (!done) begin
            state_r <= IDLE;
          end else begin
            state_r <= state_r;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_last  = out_last_r;
  assign overflow  = overflow_r;
  assign short_blk = short_r;
  assign blk_count = blk_count_r;

endmodule

// File: tb/tb_dct_block_collector.sv
// Scoreboard bench for dct_block_collector: a block-level model of the input protocol
// predicts words and pulses; a negedge monitor pops and compares.
module tb_dct_block_collector;

  localparam int BL = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        done = 1'b0;
  logic [31:0] din = 32'd0;
  logic        out_ready = 1'b0;
  logic        out_valid, out_last, overflow, short_blk;
  logic [31:0] out_data;
  logic [15:0] blk_count;

  dct_block_collector dut (
    .clk(clk), .reset(reset), .done(done), .din(din),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .overflow(overflow), .short_blk(short_blk),
    .blk_count(blk_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] blk_q[$];
  int          n_vec = 0;
  int          n_bad = 0;
  int          completed = 0, drained = 0;
  int          ovf_seen = 0, short_seen = 0;
  logic        m_prev = 1'b1, m_in_blk = 1'b0, m_collect = 1'b0;
  logic        ovf_pend = 1'b0, short_pend = 1'b0;
  logic [15:0] exp_blk = 16'd0;
  logic        stalled = 1'b0, stall_last;
  logic [31:0] stall_data;
  logic        rnd_ready = 1'b0;

  // Expected stream word: the top 14 bits of the coefficient as a signed value.
  function automatic logic [31:0] rq(input logic [31:0] w);
    return 32'($signed(w) >>> 18);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor first (so a drain on this edge is visible), then the input model.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      check("rst_valid", {31'd0, out_valid}, 32'd0);
      check("rst_data", out_data, 32'd0);
      check("rst_last", {31'd0, out_last}, 32'd0);
      check("rst_ovf", {31'd0, overflow}, 32'd0);
      check("rst_short", {31'd0, short_blk}, 32'd0);
      check("rst_blk_count", {16'd0, blk_count}, 32'd0);
      exp_q.delete();
      blk_q.delete();
      completed = 0; drained = 0;
      m_prev = 1'b1; m_in_blk = 1'b0; m_collect = 1'b0;
      ovf_pend = 1'b0; short_pend = 1'b0; exp_blk = 16'd0; stalled = 1'b0;
    end else begin
      check("overflow", {31'd0, overflow}, {31'd0, ovf_pend});
      check("short_blk", {31'd0, short_blk}, {31'd0, short_pend});
      check("blk_count", {16'd0, blk_count}, {16'd0, exp_blk});
      if (overflow) ovf_seen++;
      if (short_blk) short_seen++;
      if (stalled) begin
        check("stall_data", out_data, stall_data);
        check("stall_last", {31'd0, out_last}, {31'd0, stall_last});
      end
      if (out_valid && out_ready) begin
        stalled = 1'b0;
        if (exp_q.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL unexpected_word: got %0h, required no word at %0t", out_data, $time);
        end else begin
          e = exp_q.pop_front();
          check("out_data", out_data, e.data);
          check("out_last", {31'd0, out_last}, {31'd0, e.last});
          if (e.last) drained++;
        end
      end else if (out_valid) begin
        stalled = 1'b1; stall_data = out_data; stall_last = out_last;
      end else begin
        stalled = 1'b0;
      end
      // block-level model: two buffers, block accepted only if one is free
      ovf_pend = 1'b0;
      short_pend = 1'b0;
      if (done && !m_prev && !m_in_blk) begin
        m_in_blk = 1'b1;
        if (completed - drained >= 2) begin
          ovf_pend = 1'b1; m_collect = 1'b0;
        end else begin
          m_collect = 1'b1; blk_q.delete();
        end
      end
      if (m_in_blk) begin
        if (!done) begin
          if (m_collect) short_pend = 1'b1;
          m_in_blk = 1'b0; m_collect = 1'b0;
        end else if (m_collect) begin
          blk_q.push_back(rq(din));
          if (blk_q.size() == BL) begin
            for (int i = 0; i < BL; i++) exp_q.push_back('{data: blk_q[i], last: (i == BL - 1)});
            completed++; exp_blk = exp_blk + 16'd1; m_collect = 1'b0;
          end
        end
      end
      m_prev = done;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  // kind 0: k<<18 ramp; 1: random words; 2: ramp with two sign-extension probes
  task automatic send_block(input int n, input int kind);
    for (int i = 0; i < n; i++) begin
      done = 1'b1;
      if (kind == 1) din = $urandom;
      else if (kind == 2 && i == 0) din = 32'hFFFC_0000;
      else if (kind == 2 && i == 1) din = 32'h8000_0000;
      else din = 32'(i) << 18;
      tick();
    end
    done = 1'b0;
    din = 32'd0;
    tick();
  endtask

  task automatic wait_drain(input string name);
    int c;
    c = 0;
    while ((exp_q.size() != 0 || out_valid) && c < 3000) begin
      tick();
      c++;
    end
    n_vec++;
    if (c >= 3000) begin
      n_bad++;
      $display("FAIL %s_timeout: got %0d words pending, required 0", name, exp_q.size());
    end
  endtask

  initial begin
    int o0, s0;
    repeat (3) tick();
    reset = 1'b1;
    tick();

    // single block ramp
    out_ready = 1'b1;
    send_block(64, 0);
    wait_drain("single");
    check("single_blk_count", {16'd0, blk_count}, 32'd1);

    // sign extension probes
    send_block(64, 2);
    wait_drain("sign");

    // backpressure ping-pong with a dropped third block
    out_ready = 1'b0;
    o0 = ovf_seen;
    send_block(64, 0);
    send_block(64, 1);
    send_block(64, 0);
    repeat (2) tick();
    check("bp_overflow_cnt", 32'(ovf_seen - o0), 32'd1);
    check("bp_blk_count", {16'd0, blk_count}, 32'd4);
    out_ready = 1'b1;
    for (int i = 0; i < 2 * BL; i++) begin
      @(negedge clk);
      check("bp_no_gap", {31'd0, out_valid}, 32'd1);
    end
    tick();
    wait_drain("bp");

    // short block then a normal one
    s0 = short_seen;
    send_block(40, 1);
    repeat (3) tick();
    check("short_cnt", 32'(short_seen - s0), 32'd1);
    check("short_no_valid", {31'd0, out_valid}, 32'd0);
    send_block(64, 1);
    wait_drain("after_short");
    check("short_blk_count", {16'd0, blk_count}, 32'd5);

    // long done
    send_block(70, 0);
    wait_drain("long");
    check("long_blk_count", {16'd0, blk_count}, 32'd6);

    // reset mid-capture with a pending block in the other bank
    out_ready = 1'b0;
    send_block(64, 1);
    for (int i = 0; i < 30; i++) begin
      done = 1'b1; din = $urandom; tick();
    end
    reset = 1'b0;
    #1;
    check("async_rst_valid", {31'd0, out_valid}, 32'd0);
    check("async_rst_blk", {16'd0, blk_count}, 32'd0);
    repeat (2) tick();
    reset = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      din = $urandom; tick();
    end
    check("post_rst_valid", {31'd0, out_valid}, 32'd0);
    check("post_rst_blk", {16'd0, blk_count}, 32'd0);
    done = 1'b0;
    tick();
    send_block(64, 0);
    wait_drain("post_rst");
    check("post_rst_blk_count", {16'd0, blk_count}, 32'd1);

    // randomized block lengths, gaps and backpressure
    rnd_ready = 1'b1;
    for (int b = 0; b < 30; b++) begin
      int sel, len;
      sel = $urandom_range(0, 3);
      len = (sel == 0) ? 64 : (sel == 1) ? 70 : (sel == 2) ? 40 : $urandom_range(1, 80);
      send_block(len, 1);
      repeat ($urandom_range(0, 4)) tick();
    end
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    wait_drain("random");
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
